// File: rtl/fifo_arb_pkg.sv
// Shared defaults, credit type and index helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  // Widest requester vector the arbiter supports; onehot2idx works at this width.
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned IDX_MAX_W = 3;

  typedef logic [$clog2(FIFO_DEPTH_DEF):0] credit_t;

  function automatic logic [IDX_MAX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index after last_grant, with wrap.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    w_idx    = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_idx = IDX_W'((32'(last_grant_i) + off) % NUM_REQ);
      if (!valid_o && eligible_i[w_idx]) begin
        winner_o[w_idx] = 1'b1;
        valid_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-gated sharing of one FIFO write port with ack/overflow checking.
// Define FIFO_ARB_STATS_EN to add per-requester 16-bit saturating grant counters (stat_cnt_o).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned  NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned  DATA_W     = DATA_W_DEF,
  parameter int unsigned  FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned CREDIT_W   = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      fifo_wr_en_o,
  output logic [DATA_W-1:0]         fifo_data_o,
  input  logic                      fifo_rd_en_i,
  input  logic                      fifo_empty_i,
  input  logic                      fifo_wr_ack_i,
  input  logic                      fifo_overflow_i,
  output logic [CREDIT_W-1:0]       credit_o,
  output logic                      err_o
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_cnt_o
`endif
);

  logic [NUM_REQ-1:0]  r_gnt;
  logic                r_wr_en;
  logic [DATA_W-1:0]   r_data;
  logic [IDX_W-1:0]    r_last_grant;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_exp_ack;
  logic                r_err;

  logic [NUM_REQ-1:0]  w_eligible;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic                w_win_valid;
  logic [IDX_W-1:0]    w_win_idx;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_rd;
  logic                w_issue;
  logic                w_rd_ovf;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_err_nxt;

  // Mask the requester whose grant is visible so a held request is taken only once.
  assign w_eligible = req_i & ~r_gnt;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .eligible_i   (w_eligible),
    .last_grant_i (r_last_grant),
    .winner_o     (w_win_oh),
    .valid_o      (w_win_valid)
  );

  assign w_win_idx = IDX_W'(onehot2idx(MAX_REQ'(w_win_oh)));
  assign w_rd      = fifo_rd_en_i & ~fifo_empty_i;
  assign w_issue   = arb_en & w_win_valid & (r_credit != '0);

  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win_oh[k]) w_win_data = w_win_data | req_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Credit is taken at issue, so an in-flight write already counts as occupied.
  always_comb begin
    w_credit_nxt = r_credit;
    w_rd_ovf     = 1'b0;
    if (w_issue && !w_rd) begin
      w_credit_nxt = r_credit - CREDIT_W'(1);
    end else if (w_rd && !w_issue) begin
      if (r_credit == CREDIT_W'(FIFO_DEPTH)) begin
        w_rd_ovf = 1'b1;
      end else begin
        w_credit_nxt = r_credit + CREDIT_W'(1);
      end
    end
  end

  assign w_err_nxt = r_err | w_rd_ovf | (fifo_wr_ack_i != r_exp_ack) | fifo_overflow_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt        <= '0;
      r_wr_en      <= 1'b0;
      r_data       <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_credit     <= CREDIT_W'(FIFO_DEPTH);
      r_exp_ack    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_exp_ack <= r_wr_en;
      r_err     <= w_err_nxt;
      r_credit  <= w_credit_nxt;
      if (w_issue) begin
        r_gnt        <= w_win_oh;
        r_wr_en      <= 1'b1;
        r_data       <= w_win_data;
        r_last_grant <= w_win_idx;
      end else begin
        r_gnt   <= '0;
        r_wr_en <= 1'b0;
      end
    end
  end

  assign gnt_o        = r_gnt;
  assign fifo_wr_en_o = r_wr_en;
  assign fifo_data_o  = r_data;
  assign credit_o     = r_credit;
  assign err_o        = r_err;

`ifdef FIFO_ARB_STATS_EN
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (r_gnt[k] && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign stat_cnt_o[k*16 +: 16] = r_cnt;
  end
`endif

endmodule
